// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI-Lite requester arbiter and its helpers.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_D = 3'd4,
    RESP = 3'd5
  } axil_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Index width for n entries; a single entry still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by ptr, take the lowest set
// bit, rotate the one-hot result back.
module rr_arbiter
  import axil_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [idx_width(NUM_REQ)-1:0]   ptr,
  output logic [NUM_REQ-1:0]              grant,
  output logic [idx_width(NUM_REQ)-1:0]   grant_idx,
  output logic                            any
);

  localparam int unsigned PTR_W = idx_width(NUM_REQ);
  localparam int unsigned SUM_W = PTR_W + 1;

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_g;
  logic [SUM_W-1:0]   back_sh;
  logic [SUM_W-1:0]   sum;

  assign back_sh = SUM_W'(NUM_REQ) - SUM_W'(ptr);

  // Rotating left by (NUM_REQ - ptr) makes shifts by NUM_REQ drop out cleanly when ptr is 0.
  assign rot   = (req >> ptr) | (req << back_sh);
  assign grant = (rot_g << ptr) | (rot_g >> back_sh);

  always_comb begin
    rot_g = '0;
    sum   = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && rot[i]) begin
        any      = 1'b1;
        rot_g[i] = 1'b1;
        sum      = SUM_W'(ptr) + SUM_W'(i);
      end
    end
    grant_idx = (sum >= SUM_W'(NUM_REQ)) ? PTR_W'(sum - SUM_W'(NUM_REQ)) : PTR_W'(sum);
  end

endmodule

// File: rtl/axil_req_arb.sv
// Round-robin arbiter sharing one AXI-Lite master port between NUM_REQ simple
// register-access requesters; one outstanding single-beat transaction at a time.
module axil_req_arb
  import axil_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                               aclk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]    req_wstrb,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic [1:0]                         rsp_resp,
  output logic [ADDR_WIDTH-1:0]              m_axil_awaddr,
  output logic [2:0]                         m_axil_awprot,
  output logic                               m_axil_awvalid,
  input  logic                               m_axil_awready,
  output logic [DATA_WIDTH-1:0]              m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0]            m_axil_wstrb,
  output logic                               m_axil_wvalid,
  input  logic                               m_axil_wready,
  input  logic [1:0]                         m_axil_bresp,
  input  logic                               m_axil_bvalid,
  output logic                               m_axil_bready,
  output logic [ADDR_WIDTH-1:0]              m_axil_araddr,
  output logic [2:0]                         m_axil_arprot,
  output logic                               m_axil_arvalid,
  input  logic                               m_axil_arready,
  input  logic [DATA_WIDTH-1:0]              m_axil_rdata,
  input  logic [1:0]                         m_axil_rresp,
  input  logic                               m_axil_rvalid,
  output logic                               m_axil_rready
);

  localparam int unsigned PTR_W  = idx_width(NUM_REQ);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  axil_state_t state, state_next;

  logic [PTR_W-1:0]      rr_ptr, owner;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  aw_done, w_done, aw_done_next, w_done_next;

  logic [NUM_REQ-1:0]    grant, owner_oh;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any, take;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_W-1:0]     sel_wstrb;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign take = (state == IDLE) && grant_any;

  // Ready is the arbitration result itself, forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (take && !rst) req_ready = grant;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) owner_oh[i] = (owner == PTR_W'(i));
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    aw_done_next = 1'b0;
    w_done_next  = 1'b0;
    case (state)
      IDLE: if (grant_any) state_next = sel_we ? WR : RD_A;
      WR: begin
        aw_done_next = aw_done | (m_axil_awvalid & m_axil_awready);
        w_done_next  = w_done  | (m_axil_wvalid  & m_axil_wready);
        if (aw_done_next && w_done_next) state_next = WR_B;
      end
      WR_B: if (m_axil_bvalid && m_axil_bready)   state_next = RESP;
      RD_A: if (m_axil_arvalid && m_axil_arready) state_next = RD_D;
      RD_D: if (m_axil_rvalid && m_axil_rready)   state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Channel controls are registered from the next state so valids never follow ready combinationally.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      rr_ptr         <= '0;
      owner          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      rsp_resp       <= RESP_OKAY;
    end else begin
      aw_done        <= (state_next == WR) && aw_done_next;
      w_done         <= (state_next == WR) && w_done_next;
      m_axil_awvalid <= (state_next == WR) && !aw_done_next;
      m_axil_wvalid  <= (state_next == WR) && !w_done_next;
      m_axil_bready  <= (state_next == WR_B);
      m_axil_arvalid <= (state_next == RD_A);
      m_axil_rready  <= (state_next == RD_D);

      if (take) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        wstrb_q <= sel_wstrb;
        owner   <= grant_idx;
        rr_ptr  <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end

      rsp_valid <= (state_next == RESP) ? owner_oh : '0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
      if (state == WR_B && m_axil_bvalid && m_axil_bready) rsp_resp <= m_axil_bresp;
      if (state == RD_D && m_axil_rvalid && m_axil_rready) begin
        rsp_rdata <= m_axil_rdata;
        rsp_resp  <= m_axil_rresp;
      end
    end
  end

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign m_axil_awprot = PROT;
  assign m_axil_arprot = PROT;

endmodule

// File: tb/tb_axil_req_arb.sv
// Directed cycle-by-cycle bench for axil_req_arb with a hand-driven AXI-Lite slave.
module tb_axil_req_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic aclk = 1'b0;
  logic rst;

  logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*DW/8-1:0] req_wstrb;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;

  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]    m_axil_awprot, m_axil_arprot;
  logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [DW-1:0] m_axil_wdata, m_axil_rdata;
  logic [3:0]    m_axil_wstrb;
  logic [1:0]    m_axil_bresp, m_axil_rresp;
  logic          m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic          m_axil_rvalid, m_axil_rready;

  int total = 0;
  int bad   = 0;

  axil_req_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(3'b000)) dut (
    .aclk(aclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_we[i]          = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*4 +: 4]  = s;
    req_valid[i]       = 1'b1;
  endtask

  // Zero-wait write: grant at cycle 0, AW/W at 1, B at 2, response at 3.
  task automatic zw_write(input logic [3:0] g, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] br, input string tag);
    #1 chk($sformatf("%s_gnt", tag), 64'(req_ready), 64'(g));
    tick(); req_valid = req_valid & ~g; m_axil_awready = 1'b1; m_axil_wready = 1'b1;
    #1 chk($sformatf("%s_awwv", tag), 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'h6);
    chk($sformatf("%s_awaddr", tag), 64'(m_axil_awaddr), 64'(a));
    chk($sformatf("%s_wdata", tag), 64'(m_axil_wdata), 64'(d));
    chk($sformatf("%s_wstrb", tag), 64'(m_axil_wstrb), 64'(s));
    tick(); m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b1; m_axil_bresp = br;
    #1 chk($sformatf("%s_bready", tag), 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'h1);
    tick(); m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
    #1 chk($sformatf("%s_rsp", tag), 64'(rsp_valid), 64'(g));
    chk($sformatf("%s_resp", tag), 64'(rsp_resp), 64'(br));
    chk($sformatf("%s_rdata0", tag), 64'(rsp_rdata), 64'h0);
    chk($sformatf("%s_nogntresp", tag), 64'(req_ready), 64'h0);
    tick();
    chk($sformatf("%s_rsp_once", tag), 64'(rsp_valid), 64'h0);
  endtask

  // Zero-wait read: grant at cycle 0, AR at 1, R at 2, response at 3.
  task automatic zw_read(input logic [3:0] g, input logic [31:0] a, input logic [31:0] rd,
                         input bit drop, input string tag);
    #1 chk($sformatf("%s_gnt", tag), 64'(req_ready), 64'(g));
    tick(); if (drop) req_valid = req_valid & ~g; m_axil_arready = 1'b1;
    #1 chk($sformatf("%s_arvalid", tag), 64'({m_axil_arvalid, m_axil_rready}), 64'h2);
    chk($sformatf("%s_araddr", tag), 64'(m_axil_araddr), 64'(a));
    tick(); m_axil_arready = 1'b0; m_axil_rvalid = 1'b1; m_axil_rdata = rd; m_axil_rresp = 2'b00;
    #1 chk($sformatf("%s_rready", tag), 64'({m_axil_arvalid, m_axil_rready}), 64'h1);
    tick(); m_axil_rvalid = 1'b0; m_axil_rdata = '0;
    #1 chk($sformatf("%s_rsp", tag), 64'(rsp_valid), 64'(g));
    chk($sformatf("%s_rdata", tag), 64'(rsp_rdata), 64'(rd));
    chk($sformatf("%s_resp", tag), 64'(rsp_resp), 64'h0);
    chk($sformatf("%s_nogntresp", tag), 64'(req_ready), 64'h0);
    tick();
  endtask

  int order [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = '0; m_axil_rresp = 2'b00;
    repeat (2) tick();

    // Reset state
    chk("rst_ctrl", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready}), 64'h0);
    chk("rst_rsp", 64'({rsp_valid, rsp_resp}), 64'h0);
    chk("rst_rdata", 64'(rsp_rdata), 64'h0);
    chk("rst_payload", 64'({m_axil_awaddr, m_axil_wdata}), 64'h0);
    chk("rst_prot", 64'({m_axil_awprot, m_axil_arprot}), 64'h0);
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    #1 chk("rst_ready_held", 64'(req_ready), 64'h0);
    tick(); rst = 1'b0;

    // Single zero-wait write from port 0
    zw_write(4'b0001, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, "wr0");

    // Read from port 1 with arready stalled 3 cycles and rvalid 2 more
    set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    #1 chk("rd_gnt", 64'(req_ready), 64'h2);
    tick(); req_valid[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("rd_arstall%0d", c), 64'({m_axil_arvalid, m_axil_araddr}), {31'h0, 1'b1, 32'h20});
      tick();
    end
    m_axil_arready = 1'b1;
    #1 chk("rd_arhs", 64'({m_axil_arvalid, m_axil_araddr}), {31'h0, 1'b1, 32'h20});
    tick(); m_axil_arready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1 chk($sformatf("rd_rstall%0d", c), 64'({m_axil_arvalid, m_axil_rready, rsp_valid}), 64'h10);
      chk($sformatf("rd_araddr_hold%0d", c), 64'(m_axil_araddr), 64'h20);
      tick();
    end
    m_axil_rvalid = 1'b1; m_axil_rdata = 32'h12345678; m_axil_rresp = 2'b00;
    #1 chk("rd_rready", 64'(m_axil_rready), 64'h1);
    tick(); m_axil_rvalid = 1'b0; m_axil_rdata = '0;
    #1 chk("rd_rsp", 64'(rsp_valid), 64'h2);
    chk("rd_rdata", 64'(rsp_rdata), 64'h12345678);
    chk("rd_resp", 64'(rsp_resp), 64'h0);
    tick();
    chk("rd_rsp_once", 64'(rsp_valid), 64'h0);

    // Split write: AW accepted in cycle 1, W in cycle 4
    set_req(0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'h3);
    #1 chk("sw_gnt", 64'(req_ready), 64'h1);
    tick(); req_valid[0] = 1'b0; m_axil_awready = 1'b1;
    #1 chk("sw_c1", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'h6);
    tick(); m_axil_awready = 1'b0;
    #1 chk("sw_c2", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'h2);
    tick();
    #1 chk("sw_c3", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'h2);
    chk("sw_wpay", 64'({m_axil_wstrb, m_axil_wdata}), {28'h0, 4'h3, 32'hA5A5A5A5});
    tick(); m_axil_wready = 1'b1;
    #1 chk("sw_c4", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'h2);
    tick(); m_axil_wready = 1'b0; m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
    #1 chk("sw_c5", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'h1);
    tick(); m_axil_bvalid = 1'b0;
    #1 chk("sw_rsp", 64'(rsp_valid), 64'h1);
    tick();

    // Slave error on a write from port 2, then a normal read
    set_req(2, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF);
    zw_write(4'b0100, 32'h80, 32'hCAFEF00D, 4'hF, 2'b10, "err2");
    set_req(0, 1'b0, 32'h84, 32'h0, 4'h0);
    zw_read(4'b0001, 32'h84, 32'h0BADCAFE, 1'b1, "after_err");

    // Reset asserted while in RD_D
    set_req(1, 1'b0, 32'h30, 32'h0, 4'h0);
    #1 chk("mr_gnt", 64'(req_ready), 64'h2);
    tick(); req_valid[1] = 1'b0; m_axil_arready = 1'b1;
    tick(); m_axil_arready = 1'b0;
    #1 chk("mr_rd_d", 64'(m_axil_rready), 64'h1);
    set_req(3, 1'b0, 32'h3C, 32'h0, 4'h0);
    #1 rst = 1'b1;
    #1 chk("mr_ctrl", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready}), 64'h0);
    chk("mr_rsp_ready", 64'({rsp_valid, req_ready}), 64'h0);
    chk("mr_ptr", 64'(dut.rr_ptr), 64'h0);
    chk("mr_araddr", 64'(m_axil_araddr), 64'h0);
    tick(); rst = 1'b0;
    zw_read(4'b1000, 32'h3C, 32'h5555AAAA, 1'b1, "post_rst");

    // Fairness: all ports reading continuously, port 1 drops after six grants
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'(32'h100 + 4 * i), 32'h0, 4'h0);
    for (int k = 0; k < 10; k++) begin
      if (k == 6) req_valid[1] = 1'b0;
      zw_read(4'(1 << order[k]), 32'(32'h100 + 4 * order[k]), 32'(32'h1000 + order[k]), 1'b0,
              $sformatf("fair%0d", k));
    end
    req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
